// File: rtl/snake_object_gen.sv
// snake_object_gen: snake movement, collisions, apple pulse and per-pixel object codes; SNAKE_SPEEDUP_EN enables per-apple tick shortening
module snake_object_gen #(
  parameter int MAX_LEN     = 16,
  parameter int TICK_CYCLES = 6250000,
  parameter int TICK_STEP   = 250000,
  parameter int TICK_MIN    = 1250000
) (
  input  logic       Clk_25mhz,
  input  logic       Rst,
  input  logic [9:0] Pixel_x,
  input  logic [9:0] Pixel_y,
  input  logic [1:0] Dir_in,
  input  logic       Dir_valid,
  input  logic       Start,
  input  logic [5:0] Apple_x,
  input  logic [4:0] Apple_y,
  output logic [1:0] Object,
  output logic       Apple_eaten,
  output logic       Game_over,
  output logic [5:0] Snake_len,
  output logic [5:0] Head_x,
  output logic [4:0] Head_y
);
  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;
  state_t r_state, w_next;
  logic [5:0] r_seg_x [MAX_LEN];
  logic [4:0] r_seg_y [MAX_LEN];
  logic [5:0] r_len;
  logic [1:0] r_dir, r_pend;
  logic [31:0] r_cnt, w_period;
  logic [5:0] w_nx, w_cx, w_cy;
  logic [4:0] w_ny;
  logic w_init, w_tick, w_hit, w_grow, w_self, w_die, w_in, w_pwall, w_pbody, r_eat;
`ifdef SNAKE_SPEEDUP_EN
  logic [31:0] r_period;
  // move period shrinks by one step per apple, floored
  always_ff @(posedge Clk_25mhz)
    if (Rst || w_init) r_period <= 32'(TICK_CYCLES);
    else if (w_tick && !w_die && w_hit) r_period <= (r_period >= 32'(TICK_MIN + TICK_STEP)) ? r_period - 32'(TICK_STEP) : 32'(TICK_MIN);
  assign w_period = r_period;
`else
  assign w_period = 32'(TICK_CYCLES);
`endif
  // state register
  always_ff @(posedge Clk_25mhz) r_state <= Rst ? IDLE : w_next;
  // start from IDLE/DEAD re-initialises, a colliding tick kills
  always_comb begin
    w_init = (r_state != RUN) && Start;
    w_next = w_init ? RUN : (w_tick && w_die) ? DEAD : r_state;
  end
  // candidate head cell, growth and collision decision for this tick
  always_comb begin
    w_tick = (r_state == RUN) && (r_cnt == w_period - 32'd1);
    w_nx = r_pend == 2'b11 ? r_seg_x[0] + 6'd1 : r_pend == 2'b10 ? r_seg_x[0] - 6'd1 : r_seg_x[0];
    w_ny = r_pend == 2'b01 ? r_seg_y[0] + 5'd1 : r_pend == 2'b00 ? r_seg_y[0] - 5'd1 : r_seg_y[0];
    w_hit = (w_nx == Apple_x) && (w_ny == Apple_y);
    w_grow = w_hit && (r_len < 6'(MAX_LEN));
    w_self = 1'b0;
    for (int i = 1; i < MAX_LEN; i++)
      if (r_seg_x[i] == w_nx && r_seg_y[i] == w_ny && 6'(i) + (w_grow ? 6'd0 : 6'd1) < r_len) w_self = 1'b1;
    w_die = w_nx == 6'd0 || w_nx == 6'd39 || w_ny == 5'd0 || w_ny == 5'd29 || w_self;
  end
  // classify the scanned pixel's cell against borders and body
  always_comb begin
    w_cx = Pixel_x[9:4];
    w_cy = Pixel_y[9:4];
    w_in = (Pixel_x < 10'd640) && (Pixel_y < 10'd480);
    w_pwall = w_cx == 6'd0 || w_cx == 6'd39 || w_cy == 6'd0 || w_cy == 6'd29;
    w_pbody = 1'b0;
    for (int i = 1; i < MAX_LEN; i++)
      if (r_seg_x[i] == w_cx && {1'b0, r_seg_y[i]} == w_cy && 6'(i) < r_len) w_pbody = 1'b1;
  end
  // registered object code, WALL over HEAD over BODY
  always_ff @(posedge Clk_25mhz)
    if (Rst) Object <= 2'b00;
    else Object <= !w_in ? 2'b00 : w_pwall ? 2'b11 : (w_cx == r_seg_x[0] && w_cy == {1'b0, r_seg_y[0]}) ? 2'b01 : w_pbody ? 2'b10 : 2'b00;
  // snake body shift, length and direction registers
  always_ff @(posedge Clk_25mhz) begin
    if (Rst || w_init) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= i == 0 ? 6'd20 : i == 1 ? 6'd19 : 6'd18;
        r_seg_y[i] <= 5'd15;
      end
      r_len <= 6'd3;
      r_dir <= 2'b11;
      r_pend <= 2'b11;
    end else begin
      if (Dir_valid && Dir_in != {r_dir[1], ~r_dir[0]}) r_pend <= Dir_in;
      if (w_tick) r_dir <= r_pend;
      if (w_tick && !w_die) begin
        for (int i = 1; i < MAX_LEN; i++) begin
          r_seg_x[i] <= r_seg_x[i-1];
          r_seg_y[i] <= r_seg_y[i-1];
        end
        r_seg_x[0] <= w_nx;
        r_seg_y[0] <= w_ny;
        if (w_grow) r_len <= r_len + 6'd1;
      end
    end
  end
  // tick counter runs only in RUN; apple pulse on a surviving tick
  always_ff @(posedge Clk_25mhz) begin
    if (Rst) begin
      r_cnt <= 32'd0;
      r_eat <= 1'b0;
    end else begin
      r_cnt <= (r_state != RUN || w_tick) ? 32'd0 : r_cnt + 32'd1;
      r_eat <= w_tick && !w_die && w_hit;
    end
  end
  assign Apple_eaten = r_eat;
  assign Game_over = r_state == DEAD;
  assign Snake_len = r_len;
  assign Head_x = r_seg_x[0];
  assign Head_y = r_seg_y[0];
endmodule

// File: tb/tb_snake_object_gen.sv
// tb_snake_object_gen: table, directed and random checks of snake_object_gen against a queue-based game model
module tb_snake_object_gen;
  localparam int MAXL = 8;
`ifdef SNAKE_SPEEDUP_EN
  localparam int TC = 20;
`else
  localparam int TC = 10;
`endif
  localparam int TS = 5;
  localparam int TM = 10;
  logic clk = 1'b0, rst, start, dv;
  logic [9:0] px, py;
  logic [1:0] din;
  logic [5:0] ax;
  logic [4:0] ay;
  logic [1:0] Object;
  logic Apple_eaten, Game_over;
  logic [5:0] Snake_len, Head_x;
  logic [4:0] Head_y;
  int checks = 0, errors = 0;
  int qx[$], qy[$];
  int m_state, m_dir, m_pend, m_cnt, m_per;
  int m_obj, m_eat;
  typedef struct { logic [9:0] px; logic [9:0] py; logic [1:0] obj; } vec_t;
  vec_t tbl[15];

  snake_object_gen #(.MAX_LEN(MAXL), .TICK_CYCLES(TC), .TICK_STEP(TS), .TICK_MIN(TM)) dut (
    .Clk_25mhz(clk), .Rst(rst), .Pixel_x(px), .Pixel_y(py), .Dir_in(din), .Dir_valid(dv),
    .Start(start), .Apple_x(ax), .Apple_y(ay), .Object(Object), .Apple_eaten(Apple_eaten),
    .Game_over(Game_over), .Snake_len(Snake_len), .Head_x(Head_x), .Head_y(Head_y));

  always #20 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void m_init();
    qx = '{20, 19, 18};
    qy = '{15, 15, 15};
    m_dir = 3;
    m_pend = 3;
    m_cnt = 0;
    m_per = TC;
  endfunction

  function automatic int m_lookup(int x, int y);
    int cx = x / 16;
    int cy = y / 16;
    if (x >= 640 || y >= 480) return 0;
    if (cx == 0 || cx == 39 || cy == 0 || cy == 29) return 3;
    if (cx == qx[0] && cy == qy[0]) return 1;
    for (int j = 1; j < qx.size(); j++) if (cx == qx[j] && cy == qy[j]) return 2;
    return 0;
  endfunction

  task automatic m_update();
    int npend, nx, ny, lim;
    bit hit, grow, die;
    if (rst) begin
      m_init();
      m_state = 0;
      m_eat = 0;
      m_obj = 0;
      return;
    end
    m_obj = m_lookup(int'(px), int'(py));
    m_eat = 0;
    if (m_state != 1 && start) begin
      m_init();
      m_state = 1;
      return;
    end
    npend = (dv && int'(din) != (m_dir ^ 1)) ? int'(din) : m_pend;
    if (m_state == 1 && m_cnt == m_per - 1) begin
      m_dir = m_pend;
      nx = qx[0] + (m_dir == 3 ? 1 : m_dir == 2 ? -1 : 0);
      ny = qy[0] + (m_dir == 1 ? 1 : m_dir == 0 ? -1 : 0);
      hit = nx == int'(ax) && ny == int'(ay);
      grow = hit && qx.size() < MAXL;
      die = nx == 0 || nx == 39 || ny == 0 || ny == 29;
      lim = grow ? qx.size() : qx.size() - 1;
      for (int j = 1; j < lim; j++) if (qx[j] == nx && qy[j] == ny) die = 1;
      if (die) m_state = 2;
      else begin
        qx.push_front(nx);
        qy.push_front(ny);
        if (!grow) begin
          void'(qx.pop_back());
          void'(qy.pop_back());
        end
        m_eat = int'(hit);
`ifdef SNAKE_SPEEDUP_EN
        if (hit) m_per = (m_per - TS >= TM) ? m_per - TS : TM;
`endif
      end
      m_cnt = 0;
    end else if (m_state == 1) m_cnt++;
    m_pend = npend;
  endtask

  task automatic step();
    @(posedge clk);
    m_update();
    #1;
    chk("object", int'(Object), m_obj);
    chk("apple_eaten", int'(Apple_eaten), m_eat);
    chk("game_over", int'(Game_over), int'(m_state == 2));
    chk("snake_len", int'(Snake_len), qx.size());
    chk("head_x", int'(Head_x), qx[0]);
    chk("head_y", int'(Head_y), qy[0]);
  endtask

  task automatic wait_tick(output int n);
    int hx = int'(Head_x);
    int hy = int'(Head_y);
    logic go = Game_over;
    n = 0;
    do begin
      step();
      n++;
    end while (int'(Head_x) == hx && int'(Head_y) == hy && Game_over == go && n < 4 * TC);
    if (n >= 4 * TC) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout actual %0d required <%0d", n, 4 * TC);
    end
  endtask

  task automatic turn(input logic [1:0] d);
    dv = 1'b1;
    din = d;
    step();
    dv = 1'b0;
  endtask

  task automatic restart(input int x, input int y);
    rst = 1'b1;
    step();
    rst = 1'b0;
    ax = 6'(x);
    ay = 5'(y);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int n, exp_per;
    tbl[0] = '{10'd320, 10'd240, 2'b01};
    tbl[1] = '{10'd335, 10'd255, 2'b01};
    tbl[2] = '{10'd304, 10'd240, 2'b10};
    tbl[3] = '{10'd288, 10'd250, 2'b10};
    tbl[4] = '{10'd272, 10'd240, 2'b00};
    tbl[5] = '{10'd336, 10'd240, 2'b00};
    tbl[6] = '{10'd0, 10'd0, 2'b11};
    tbl[7] = '{10'd639, 10'd479, 2'b11};
    tbl[8] = '{10'd624, 10'd100, 2'b11};
    tbl[9] = '{10'd100, 10'd464, 2'b11};
    tbl[10] = '{10'd16, 10'd16, 2'b00};
    tbl[11] = '{10'd640, 10'd240, 2'b00};
    tbl[12] = '{10'd320, 10'd480, 2'b00};
    tbl[13] = '{10'd1023, 10'd1023, 2'b00};
    tbl[14] = '{10'd320, 10'd15, 2'b11};
    rst = 1'b1; start = 1'b0; dv = 1'b0; din = 2'b00; px = 10'd0; py = 10'd0; ax = 6'd5; ay = 5'd5;
    m_init();
    m_state = 0; m_obj = 0; m_eat = 0;
    step();
    step();
    chk("rst_object", int'(Object), 0);
    chk("rst_eaten", int'(Apple_eaten), 0);
    chk("rst_game_over", int'(Game_over), 0);
    chk("rst_len", int'(Snake_len), 3);
    chk("rst_head_x", int'(Head_x), 20);
    chk("rst_head_y", int'(Head_y), 15);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      px = tbl[i].px;
      py = tbl[i].py;
      step();
      chk("table_object", int'(Object), int'(tbl[i].obj));
    end
    px = 10'd336; py = 10'd240;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_tick(n);
    chk("first_tick_cycles", n, TC);
    chk("tick1_head_x", int'(Head_x), 21);
    step();
    chk("obj_head_336", int'(Object), 1);
    px = 10'd320;
    step();
    chk("obj_body_320", int'(Object), 2);
    wait_tick(n);
    chk("second_tick_cycles", n, TC - 2);
    chk("tick2_head_x", int'(Head_x), 22);
    turn(2'b10);
    step();
    turn(2'b00);
    wait_tick(n);
    chk("turn_up_x", int'(Head_x), 22);
    chk("turn_up_y", int'(Head_y), 14);
    turn(2'b01);
    wait_tick(n);
    chk("reverse_drop_x", int'(Head_x), 22);
    chk("reverse_drop_y", int'(Head_y), 13);
    px = 10'd288; py = 10'd240;
    restart(21, 15);
    wait_tick(n);
    chk("eat_pulse", int'(Apple_eaten), 1);
    chk("eat_len", int'(Snake_len), 4);
    ax = 6'd5; ay = 5'd5;
    step();
    chk("eat_pulse_end", int'(Apple_eaten), 0);
    chk("grow_tail_kept", int'(Object), 2);
    wait_tick(n);
    step();
    chk("tail_vacated", int'(Object), 0);
    chk("len_held", int'(Snake_len), 4);
    restart(21, 15);
    wait_tick(n);
    ax = 6'd22;
    wait_tick(n);
    chk("len5", int'(Snake_len), 5);
    ax = 6'd5;
    turn(2'b00);
    wait_tick(n);
    turn(2'b10);
    wait_tick(n);
    turn(2'b01);
    wait_tick(n);
    chk("self_hit_dead", int'(Game_over), 1);
    chk("self_hit_frozen_x", int'(Head_x), 21);
    chk("self_hit_frozen_y", int'(Head_y), 14);
    restart(21, 15);
    wait_tick(n);
    ax = 6'd5;
    turn(2'b00);
    wait_tick(n);
    turn(2'b10);
    wait_tick(n);
    turn(2'b01);
    wait_tick(n);
    chk("tail_cell_alive", int'(Game_over), 0);
    chk("tail_cell_x", int'(Head_x), 20);
    chk("tail_cell_y", int'(Head_y), 15);
    restart(5, 5);
    for (int k = 0; k < 18; k++) wait_tick(n);
    chk("wall_approach_x", int'(Head_x), 38);
    chk("wall_approach_alive", int'(Game_over), 0);
    wait_tick(n);
    chk("wall_dead", int'(Game_over), 1);
    chk("wall_frozen_x", int'(Head_x), 38);
    step();
    step();
    chk("dead_hold_x", int'(Head_x), 38);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_alive", int'(Game_over), 0);
    chk("restart_head_x", int'(Head_x), 20);
    chk("restart_len", int'(Snake_len), 3);
    restart(21, 15);
    for (int k = 1; k <= 7; k++) begin
      ax = 6'(20 + k);
      wait_tick(n);
`ifdef SNAKE_SPEEDUP_EN
      exp_per = (k == 1) ? TC : ((TC - (k - 1) * TS) > TM ? TC - (k - 1) * TS : TM);
`else
      exp_per = TC;
`endif
      chk("tick_period", n, exp_per);
      chk("sat_eaten", int'(Apple_eaten), 1);
      chk("sat_len", int'(Snake_len), (3 + k) < MAXL ? 3 + k : MAXL);
    end
    for (int c = 0; c < 3000; c++) begin
      int dx, dy;
      rst = $urandom_range(0, 499) == 0;
      start = $urandom_range(0, 39) == 0;
      dv = $urandom_range(0, 5) == 0;
      din = 2'($urandom_range(0, 3));
      px = 10'($urandom_range(0, 700));
      py = 10'($urandom_range(0, 520));
      if ($urandom_range(0, 2) == 0) begin
        dx = m_pend == 3 ? 1 : m_pend == 2 ? -1 : 0;
        dy = m_pend == 1 ? 1 : m_pend == 0 ? -1 : 0;
        ax = 6'(qx[0] + dx);
        ay = 5'(qy[0] + dy);
      end else begin
        ax = 6'($urandom_range(1, 38));
        ay = 5'($urandom_range(1, 28));
      end
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
